// File: rtl/odd_parity_tx.sv
// Odd-parity serial frame transmitter: start, DATA_W bits LSB-first, parity, stop.
// tx_out falls the cycle after accept; ready_out only in IDLE, so valid_in is simply held off mid-frame.
module odd_parity_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy_out,
    output logic [DATA_W:0]   frame_out,
    output logic              done_out
);

    localparam int HOLD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLKS_PER_BIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W:0]     frame_q, frame_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;

    assign bit_end = (hold_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        frame_d = frame_q;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d = START;
                    hold_d  = '0;
                    bit_d   = '0;
                    shift_d = data_in;
                    frame_d = {~^data_in, data_in};
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    hold_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register alongside it.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = frame_d[DATA_W];
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP) && (hold_d == HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            frame_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_out    = tx_q;
    assign ready_out = ready_q;
    assign busy_out  = busy_q;
    assign frame_out = frame_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_odd_parity_tx.sv
// Directed bench for odd_parity_tx: default-parameter instance plus a CLKS_PER_BIT=1 instance.
module tb_odd_parity_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out, tx_out, busy_out, done_out;
    logic [8:0] frame_out;

    logic [7:0] data1;
    logic       valid1;
    logic       ready1, tx1, busy1, done1;
    logic [8:0] frame1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] d;
        logic [8:0] ef;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    odd_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx_out(tx_out), .busy_out(busy_out),
        .frame_out(frame_out), .done_out(done_out)
    );

    odd_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .data_in(data1), .valid_in(valid1),
        .ready_out(ready1), .tx_out(tx1), .busy_out(busy1),
        .frame_out(frame1), .done_out(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (ready_out !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'd0, ready_out}, 32'd1);
    endtask

    // Entered at the negedge of the first cycle after the accept edge; leaves at cycle 45.
    task automatic check_frame(input logic [7:0] d, input logic [8:0] ef,
                               input bit hold_valid, input logic [7:0] nd);
        logic [10:0] eb;
        eb = {1'b1, ef[8], d, 1'b0};
        chk($sformatf("frame d=%h", d), {23'd0, frame_out}, {23'd0, ef});
        chk($sformatf("odd_pop d=%h", d), {31'd0, ^frame_out}, 32'd1);
        for (int k = 1; k <= 44; k++) begin
            chk($sformatf("tx d=%h k=%0d", d, k), {31'd0, tx_out}, {31'd0, eb[(k-1)/4]});
            chk($sformatf("done d=%h k=%0d", d, k), {31'd0, done_out}, {31'd0, k == 44});
            if (k == 1 || k == 44) begin
                chk($sformatf("ready d=%h k=%0d", d, k), {31'd0, ready_out}, 32'd0);
                chk($sformatf("busy d=%h k=%0d", d, k), {31'd0, busy_out}, 32'd1);
            end
            valid_in = hold_valid;
            if (hold_valid) data_in = (k == 44) ? nd : 8'($urandom);
            @(negedge clk);
        end
        chk($sformatf("ready45 d=%h", d), {31'd0, ready_out}, 32'd1);
        chk($sformatf("idle_tx d=%h", d), {31'd0, tx_out}, 32'd1);
        chk($sformatf("frame_hold d=%h", d), {23'd0, frame_out}, {23'd0, ef});
    endtask

    task automatic send(input logic [7:0] d, input logic [8:0] ef);
        wait_ready();
        data_in  = d;
        valid_in = 1'b1;
        @(negedge clk);
        check_frame(d, ef, 1'b0, 8'h00);
    endtask

    initial begin
        logic [10:0] eb1;
        int seen;
        int t;

        vecs[0] = '{d: 8'h00, ef: 9'h100};
        vecs[1] = '{d: 8'hA1, ef: 9'h0A1};
        vecs[2] = '{d: 8'hFF, ef: 9'h1FF};
        vecs[3] = '{d: 8'hC3, ef: 9'h1C3};
        vecs[4] = '{d: 8'h80, ef: 9'h080};
        vecs[5] = '{d: 8'h7F, ef: 9'h07F};

        data1    = 8'h01;
        valid1   = 1'b1;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_tx", {31'd0, tx_out}, 32'd1);
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_done", {31'd0, done_out}, 32'd0);
        chk("rst_frame", {23'd0, frame_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) send(vecs[i].d, vecs[i].ef);

        // valid held high with wandering data: only the accept-edge words go out
        wait_ready();
        data_in  = 8'h5A;
        valid_in = 1'b1;
        @(negedge clk);
        check_frame(8'h5A, 9'h15A, 1'b1, 8'h3C);
        @(negedge clk);
        check_frame(8'h3C, 9'h13C, 1'b0, 8'h00);

        // reset during DATA abandons the frame
        wait_ready();
        data_in  = 8'h96;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx_out}, 32'd1);
        chk("midrst_ready", {31'd0, ready_out}, 32'd1);
        chk("midrst_busy", {31'd0, busy_out}, 32'd0);
        chk("midrst_frame", {23'd0, frame_out}, 32'd0);
        chk("midrst_done", {31'd0, done_out}, 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_out === 1'b1) seen++;
        end
        chk("no_done_after_rst", seen, 32'd0);
        send(8'h2D, 9'h12D);

        // reset and valid together: reset wins, nothing accepted
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'h55;
        @(negedge clk);
        chk("rv_ready", {31'd0, ready_out}, 32'd1);
        chk("rv_frame", {23'd0, frame_out}, 32'd0);
        chk("rv_tx", {31'd0, tx_out}, 32'd1);
        reset    = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        chk("rv_ready2", {31'd0, ready_out}, 32'd1);
        chk("rv_tx2", {31'd0, tx_out}, 32'd1);

        // CLKS_PER_BIT=1 instance with valid tied high: 11-cycle frames, 1 idle cycle apart
        eb1 = {1'b1, 1'b0, 8'h01, 1'b0};
        t = 0;
        while (done1 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("c1_done_wait", {31'd0, done1}, 32'd1);
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            chk($sformatf("c1_idle_ready f=%0d", f), {31'd0, ready1}, 32'd1);
            chk($sformatf("c1_idle_tx f=%0d", f), {31'd0, tx1}, 32'd1);
            for (int k = 0; k < 11; k++) begin
                @(negedge clk);
                chk($sformatf("c1_tx f=%0d k=%0d", f, k), {31'd0, tx1}, {31'd0, eb1[k]});
                chk($sformatf("c1_done f=%0d k=%0d", f, k), {31'd0, done1}, {31'd0, k == 10});
                chk($sformatf("c1_busy f=%0d k=%0d", f, k), {31'd0, busy1}, 32'd1);
            end
            chk($sformatf("c1_frame f=%0d", f), {23'd0, frame1}, 32'h001);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
